// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - shared hazard-control types and the pipeline/hazard signal bundle
package hazard_ctrl_pkg;

   typedef struct packed {
      logic regwrite;
      logic memread;
      logic memwrite;
      logic pcreg;
   } control_t;

   typedef enum logic [2:0] {
      FWD_REGS    = 3'd0,
      FWD_RESULT  = 3'd1,
      FWD_PCPLUS4 = 3'd2,
      FWD_WD      = 3'd3,
      FWD_SREGWD  = 3'd4
   } fwd_sel_t;

   typedef struct packed {
      fwd_sel_t eforward1;
      fwd_sel_t eforward2;
      fwd_sel_t mforward2;
      fwd_sel_t dforward1;
      fwd_sel_t dforward2;
   } fwt_t;

endpackage

interface hazard_ctrl_if;
   logic [4:0]                d_ra1, d_ra2;
   logic [4:0]                e_ra1, e_ra2, e_dst;
   hazard_ctrl_pkg::control_t e_ctl;
   logic [4:0]                m_dst, m_ra2;
   hazard_ctrl_pkg::control_t m_ctl;
   logic [4:0]                w_dst;
   logic                      w_regwrite;
   logic [4:0]                s_wa;
   logic                      s_has;
   logic                      e_redirect;
   logic [63:0]               e_target;
   logic                      i_busy, d_busy;
   logic                      stall_f, stall_d, stall_e, stall_m;
   logic                      flush_d, flush_e, flush_m;
   hazard_ctrl_pkg::fwt_t     fwd;
   logic                      pc_sel;
   logic [63:0]               pc_target;
   logic [1:0]                state_o;

   // hazard controller side
   modport master (
      input  d_ra1, d_ra2, e_ra1, e_ra2, e_dst, e_ctl, m_dst, m_ra2, m_ctl,
             w_dst, w_regwrite, s_wa, s_has, e_redirect, e_target, i_busy, d_busy,
      output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m,
             fwd, pc_sel, pc_target, state_o
   );

   // pipeline side
   modport slave (
      output d_ra1, d_ra2, e_ra1, e_ra2, e_dst, e_ctl, m_dst, m_ra2, m_ctl,
             w_dst, w_regwrite, s_wa, s_has, e_redirect, e_target, i_busy, d_busy,
      input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m,
             fwd, pc_sel, pc_target, state_o
   );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller; HAZARD_FORWARD_EN enables operand forwarding
module hazard_ctrl
   import hazard_ctrl_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   hazard_ctrl_if.master hz
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_LDUSE = 2'd1,
      ST_DWAIT = 2'd2,
      ST_RPEND = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [63:0] target_q, target_d;

   logic        stall_f, stall_d, stall_e, stall_m;
   logic        flush_d, flush_e, flush_m;
   logic        pc_sel;
   logic [63:0] pc_target;
   fwt_t        fwd_c;
   logic        load_use, hazard;
   state_t      hazard_state;

   function automatic logic hit(input logic [4:0] dst, input logic wr, input logic [4:0] src);
      return wr && (dst != 5'd0) && (dst == src);
   endfunction

   assign load_use = hz.e_ctl.memread && (hz.e_dst != 5'd0) &&
                     ((hz.e_dst == hz.d_ra1) || (hz.e_dst == hz.d_ra2));

`ifdef HAZARD_FORWARD_EN
   function automatic fwd_sel_t e_pick(input logic [4:0] src, input logic [4:0] m_dst,
                                       input control_t m_ctl, input logic [4:0] w_dst,
                                       input logic w_wr, input logic [4:0] s_wa, input logic s_has);
      if (hit(m_dst, m_ctl.regwrite, src) && !m_ctl.memread)
         return m_ctl.pcreg ? FWD_PCPLUS4 : FWD_RESULT;
      if (hit(w_dst, w_wr, src))
         return FWD_WD;
      if (hit(s_wa, s_has, src))
         return FWD_SREGWD;
      return FWD_REGS;
   endfunction

   function automatic fwd_sel_t d_pick(input logic [4:0] src, input logic [4:0] w_dst,
                                       input logic w_wr, input logic [4:0] s_wa, input logic s_has);
      if (hit(w_dst, w_wr, src))
         return FWD_WD;
      if (hit(s_wa, s_has, src))
         return FWD_SREGWD;
      return FWD_REGS;
   endfunction

   // Forwarding selects, nearest producer first
   always_comb begin
      fwd_c.eforward1 = e_pick(hz.e_ra1, hz.m_dst, hz.m_ctl, hz.w_dst, hz.w_regwrite, hz.s_wa, hz.s_has);
      fwd_c.eforward2 = e_pick(hz.e_ra2, hz.m_dst, hz.m_ctl, hz.w_dst, hz.w_regwrite, hz.s_wa, hz.s_has);
      fwd_c.mforward2 = (hz.m_ctl.memwrite && hit(hz.w_dst, hz.w_regwrite, hz.m_ra2)) ? FWD_WD : FWD_REGS;
      fwd_c.dforward1 = d_pick(hz.d_ra1, hz.w_dst, hz.w_regwrite, hz.s_wa, hz.s_has);
      fwd_c.dforward2 = d_pick(hz.d_ra2, hz.w_dst, hz.w_regwrite, hz.s_wa, hz.s_has);
   end

   assign hazard       = load_use;
   assign hazard_state = ST_LDUSE;
`else
   // Without forwarding every operand comes from the register file
   always_comb begin
      fwd_c.eforward1 = FWD_REGS;
      fwd_c.eforward2 = FWD_REGS;
      fwd_c.mforward2 = FWD_REGS;
      fwd_c.dforward1 = FWD_REGS;
      fwd_c.dforward2 = FWD_REGS;
   end

   // Any in-flight producer of a D source holds D until it has written back
   assign hazard = load_use ||
                   hit(hz.e_dst, hz.e_ctl.regwrite, hz.d_ra1) || hit(hz.e_dst, hz.e_ctl.regwrite, hz.d_ra2) ||
                   hit(hz.m_dst, hz.m_ctl.regwrite, hz.d_ra1) || hit(hz.m_dst, hz.m_ctl.regwrite, hz.d_ra2) ||
                   hit(hz.w_dst, hz.w_regwrite, hz.d_ra1)     || hit(hz.w_dst, hz.w_regwrite, hz.d_ra2);
   assign hazard_state = ST_RUN;
`endif

   logic unused_ctl;
   assign unused_ctl = &{1'b0, hz.e_ctl, hz.m_ctl, hz.m_ra2, hz.s_wa, hz.s_has};

   // State and latched redirect target; reset drops any pending redirect
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_RUN;
         target_q <= '0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
      end
   end

   // Next state and stall/flush/redirect outputs, with the reset override last
   always_comb begin
      state_d   = state_q;
      target_d  = target_q;
      stall_f   = 1'b0;
      stall_d   = 1'b0;
      stall_e   = 1'b0;
      stall_m   = 1'b0;
      flush_d   = 1'b0;
      flush_e   = 1'b0;
      flush_m   = 1'b0;
      pc_sel    = 1'b0;
      pc_target = hz.e_target;
      if (state_q == ST_RPEND) begin
         // wrong-path fetch is drained; a memory wait only freezes M and keeps the target
         stall_f   = 1'b1;
         flush_d   = 1'b1;
         flush_e   = 1'b1;
         pc_target = target_q;
         if (hz.d_busy) begin
            stall_m = 1'b1;
         end else if (!hz.i_busy) begin
            pc_sel  = 1'b1;
            state_d = ST_RUN;
         end
      end else if (hz.d_busy) begin
         // freeze the whole pipe; bubble into M so W does not repeat its write
         stall_f = 1'b1;
         stall_d = 1'b1;
         stall_e = 1'b1;
         stall_m = 1'b1;
         flush_m = 1'b1;
         state_d = ST_DWAIT;
      end else begin
         // RUN, LDUSE and the DWAIT release cycle share one evaluation
         state_d = ST_RUN;
         if (hz.e_redirect && hz.i_busy) begin
            stall_f  = 1'b1;
            flush_d  = 1'b1;
            flush_e  = 1'b1;
            target_d = hz.e_target;
            state_d  = ST_RPEND;
         end else if (hz.e_redirect) begin
            pc_sel  = 1'b1;
            flush_d = 1'b1;
            flush_e = 1'b1;
         end else if (hazard) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
            state_d = hazard_state;
         end else if (hz.i_busy) begin
            stall_f = 1'b1;
            flush_d = 1'b1;
         end
      end
      if (reset) begin
         stall_f  = 1'b0;
         stall_d  = 1'b0;
         stall_e  = 1'b0;
         stall_m  = 1'b0;
         flush_d  = 1'b1;
         flush_e  = 1'b1;
         flush_m  = 1'b1;
         pc_sel   = 1'b0;
         state_d  = ST_RUN;
         target_d = '0;
      end
   end

   assign hz.stall_f   = stall_f;
   assign hz.stall_d   = stall_d;
   assign hz.stall_e   = stall_e;
   assign hz.stall_m   = stall_m;
   assign hz.flush_d   = flush_d;
   assign hz.flush_e   = flush_e;
   assign hz.flush_m   = flush_m;
   assign hz.pc_sel    = pc_sel;
   assign hz.pc_target = pc_target;
   assign hz.fwd       = reset ? fwt_t'('0) : fwd_c;
   assign hz.state_o   = state_q;

endmodule
